eth_rx_frame_fifo: RTL and testbench

ETH_RX_FRAME_FIFO -- requirements
Module: eth_rx_frame_fifo

---
 rtl/mac_pkg.sv | 35 +++
 rtl/eth_rx_fifo_ram.sv | 39 +++
 rtl/eth_rx_frame_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_eth_rx_frame_fifo.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types, constants and helpers for the RX MAC frame FIFO
//
// Contents:
//   MAC_DATA_WIDTH / MAC_CTRL_WIDTH : default RX MAC data and byte-keep widths
//   RX_FIFO_DEPTH / RX_FIFO_ADDR_WIDTH : default frame FIFO geometry
//   rx_fifo_entry_t : one stored beat {data, keep, last} at default widths
//   rx_wr_state_t   : write-side frame FSM states
//   sat_inc()       : saturating 32-bit increment for frame counters
package mac_pkg;

    localparam int MAC_DATA_WIDTH     = 32;
    localparam int MAC_CTRL_WIDTH     = MAC_DATA_WIDTH / 8;
    localparam int RX_FIFO_DEPTH      = 512;
    localparam int RX_FIFO_ADDR_WIDTH = $clog2(RX_FIFO_DEPTH);

    localparam logic [31:0] RX_CNT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [MAC_DATA_WIDTH-1:0] data;
        logic [MAC_CTRL_WIDTH-1:0] keep;
        logic                      last;
    } rx_fifo_entry_t;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_DROP  = 2'd2
    } rx_wr_state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == RX_CNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/eth_rx_fifo_ram.sv
// rtl/eth_rx_fifo_ram.sv - simple dual-port RAM, single clock, registered read, no reset
//
// Ports:
//   clk     : clock for both ports
//   wr_en   : write strobe, wr_data stored at wr_addr
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read strobe, rd_data loads mem[rd_addr] on the next edge
//   rd_addr : read address
//   rd_data : registered read data, holds its value while rd_en is low
module eth_rx_fifo_ram #(
    parameter int WIDTH      = 37,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The FIFO never reads an address it is writing in the same cycle
    // (reads stay below the commit point, writes at or above it), so no
    // read-during-write behaviour needs to be defined here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// rtl/eth_rx_frame_fifo.sv - store-and-forward RX frame FIFO with bad/overflow frame drop
//
// Ports:
//   i_rx_clk, i_rx_reset_n : sole clock, asynchronous active-low reset
//   i_data, i_data_keep, i_data_last, i_data_valid, i_data_err
//                          : RX MAC beat stream, no backpressure; a beat counts
//                            only when valid and keep is non-zero
//   m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_trdy
//                          : first-word-fall-through output stream, only whole
//                            good frames are ever presented
//   o_frames_ok, o_frames_bad, o_frames_overflow
//                          : saturating counts of committed, errored and
//                            overflow-dropped frames
module eth_rx_frame_fifo
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                  i_rx_clk,
    input  logic                  i_rx_reset_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [CTRL_WIDTH-1:0] i_data_keep,
    input  logic                  i_data_last,
    input  logic                  i_data_valid,
    input  logic                  i_data_err,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [CTRL_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_trdy,
    output logic [31:0]           o_frames_ok,
    output logic [31:0]           o_frames_bad,
    output logic [31:0]           o_frames_overflow
);

    localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int ENTRY_WIDTH = DATA_WIDTH + CTRL_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    rx_wr_state_t          state;
    rx_wr_state_t          state_nxt;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_nxt;
    logic [ADDR_WIDTH:0]   wr_commit;
    logic [ADDR_WIDTH:0]   wr_commit_nxt;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  accept;
    logic                  full;
    logic                  ram_we;
    logic                  inc_ok;
    logic                  inc_bad;
    logic                  inc_ovf;
    logic [ENTRY_WIDTH-1:0] wr_entry;

    assign accept   = i_data_valid && (i_data_keep != '0);
    assign wr_entry = {i_data, i_data_keep, i_data_last};

    // Full is judged against the registered read pointer only, so a beat
    // leaving the RAM this cycle does not make room for this cycle's write.
    assign full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        ram_we        = 1'b0;
        inc_ok        = 1'b0;
        inc_bad       = 1'b0;
        inc_ovf       = 1'b0;

        if (accept) begin
            case (state)
                WR_IDLE, WR_WRITE: begin
                    if (full) begin
                        // Throw away whatever part of the frame was stored
                        // and swallow the remainder in DROP.
                        wr_ptr_nxt = wr_commit;
                        inc_ovf    = 1'b1;
                        state_nxt  = i_data_last ? WR_IDLE : WR_DROP;
                    end else begin
                        ram_we = 1'b1;
                        if (i_data_last) begin
                            state_nxt = WR_IDLE;
                            if (i_data_err) begin
                                wr_ptr_nxt = wr_commit;
                                inc_bad    = 1'b1;
                            end else begin
                                wr_ptr_nxt    = wr_ptr + PTR_ONE;
                                wr_commit_nxt = wr_ptr + PTR_ONE;
                                inc_ok        = 1'b1;
                            end
                        end else begin
                            wr_ptr_nxt = wr_ptr + PTR_ONE;
                            state_nxt  = WR_WRITE;
                        end
                    end
                end
                WR_DROP: begin
                    if (i_data_last) begin
                        state_nxt = WR_IDLE;
                    end
                end
                default: begin
                    state_nxt = WR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_rx_clk or negedge i_rx_reset_n) begin
        if (!i_rx_reset_n) begin
            state     <= WR_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            wr_commit <= wr_commit_nxt;
        end
    end

    always_ff @(posedge i_rx_clk or negedge i_rx_reset_n) begin
        if (!i_rx_reset_n) begin
            o_frames_ok       <= '0;
            o_frames_bad      <= '0;
            o_frames_overflow <= '0;
        end else begin
            if (inc_ok) begin
                o_frames_ok <= sat_inc(o_frames_ok);
            end
            if (inc_bad) begin
                o_frames_bad <= sat_inc(o_frames_bad);
            end
            if (inc_ovf) begin
                o_frames_overflow <= sat_inc(o_frames_overflow);
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic                   ram_re;
    logic [ENTRY_WIDTH-1:0] ram_rd_data;

    eth_rx_fifo_ram #(
        .WIDTH      (ENTRY_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (i_rx_clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_entry),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    // ------------------------------------------------------------------
    // Read side: RAM output stage feeding one output register
    // ------------------------------------------------------------------
    logic                  avail;
    logic                  ram_valid;
    logic                  move;
    logic [DATA_WIDTH-1:0] rd_data_field;
    logic [CTRL_WIDTH-1:0] rd_keep_field;
    logic                  rd_last_field;

    assign {rd_data_field, rd_keep_field, rd_last_field} = ram_rd_data;

    // Only committed entries are visible, which is what makes the FIFO
    // store-and-forward.
    assign avail = (rd_ptr != wr_commit);

    // RAM stage hands its beat to the output register when that register
    // is empty or is being emptied this cycle.
    assign move = ram_valid && (!m_axis_tvalid || m_axis_trdy);

    // Issue a RAM read whenever the RAM stage will be free after this edge;
    // with trdy held high this sustains one beat per cycle.
    assign ram_re = avail && (!ram_valid || move);

    always_ff @(posedge i_rx_clk or negedge i_rx_reset_n) begin
        if (!i_rx_reset_n) begin
            rd_ptr        <= '0;
            ram_valid     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (ram_re) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            ram_valid <= ram_re || (ram_valid && !move);

            if (move) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= rd_data_field;
                m_axis_tkeep  <= rd_keep_field;
                m_axis_tlast  <= rd_last_field;
            end else if (m_axis_tvalid && m_axis_trdy) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb/tb_eth_rx_frame_fifo.sv - scoreboard bench for eth_rx_frame_fifo
module tb_eth_rx_frame_fifo;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;
    logic        s_err;
    logic        s_valid;
    logic        sel_b;
    logic        valid_a;
    logic        valid_b;

    logic        trdy_a_set;
    logic        trdy_b;
    logic        rand_a;
    logic        rnd_a;
    logic        trdy_a;

    logic [31:0] tdata_a, tdata_b;
    logic [3:0]  tkeep_a, tkeep_b;
    logic        tvalid_a, tvalid_b;
    logic        tlast_a, tlast_b;
    logic [31:0] ok_a, bad_a, ovf_a;
    logic [31:0] ok_b, bad_b, ovf_b;

    rx_fifo_entry_t exp_a[$];
    rx_fifo_entry_t exp_b[$];

    int n_checks = 0;
    int n_pass   = 0;
    int m_ok_a = 0, m_bad_a = 0, m_ovf_a = 0;
    int m_ok_b = 0, m_ovf_b = 0;

    logic        hold_a = 1'b0, hold_b = 1'b0;
    logic [36:0] held_a = '0, held_b = '0;

    always #5 clk = ~clk;

    assign valid_a = s_valid && !sel_b;
    assign valid_b = s_valid && sel_b;
    assign trdy_a  = rand_a ? rnd_a : trdy_a_set;

    eth_rx_frame_fifo dut_a (
        .i_rx_clk          (clk),
        .i_rx_reset_n      (rst_n),
        .i_data            (s_data),
        .i_data_keep       (s_keep),
        .i_data_last       (s_last),
        .i_data_valid      (valid_a),
        .i_data_err        (s_err),
        .m_axis_tdata      (tdata_a),
        .m_axis_tkeep      (tkeep_a),
        .m_axis_tvalid     (tvalid_a),
        .m_axis_tlast      (tlast_a),
        .m_axis_trdy       (trdy_a),
        .o_frames_ok       (ok_a),
        .o_frames_bad      (bad_a),
        .o_frames_overflow (ovf_a)
    );

    eth_rx_frame_fifo #(.FIFO_DEPTH(16)) dut_b (
        .i_rx_clk          (clk),
        .i_rx_reset_n      (rst_n),
        .i_data            (s_data),
        .i_data_keep       (s_keep),
        .i_data_last       (s_last),
        .i_data_valid      (valid_b),
        .i_data_err        (s_err),
        .m_axis_tdata      (tdata_b),
        .m_axis_tkeep      (tkeep_b),
        .m_axis_tvalid     (tvalid_b),
        .m_axis_tlast      (tlast_b),
        .m_axis_trdy       (trdy_b),
        .o_frames_ok       (ok_b),
        .o_frames_bad      (bad_b),
        .o_frames_overflow (ovf_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        #1 rnd_a = 1'($urandom_range(0, 1));
    end

    // Monitors: pop and compare every transferred beat, and check that a
    // stalled beat is still presented unchanged one cycle later.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_a) begin
                check("a_stall_valid", 64'(tvalid_a), 64'(1));
                check("a_stall_beat", 64'({tdata_a, tkeep_a, tlast_a}), 64'(held_a));
            end
            if (tvalid_a && trdy_a) begin
                if (exp_a.size() == 0) begin
                    n_checks++;
                    $display("FAIL a_unexpected_beat: got %h expected no beat", {tdata_a, tkeep_a, tlast_a});
                end else begin
                    check("a_beat", 64'({tdata_a, tkeep_a, tlast_a}), 64'(exp_a.pop_front()));
                end
            end
            hold_a <= tvalid_a && !trdy_a;
            held_a <= {tdata_a, tkeep_a, tlast_a};
        end else begin
            hold_a <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_b) begin
                check("b_stall_valid", 64'(tvalid_b), 64'(1));
                check("b_stall_beat", 64'({tdata_b, tkeep_b, tlast_b}), 64'(held_b));
            end
            if (tvalid_b && trdy_b) begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_unexpected_beat: got %h expected no beat", {tdata_b, tkeep_b, tlast_b});
                end else begin
                    check("b_beat", 64'({tdata_b, tkeep_b, tlast_b}), 64'(exp_b.pop_front()));
                end
            end
            hold_b <= tvalid_b && !trdy_b;
            held_b <= {tdata_b, tkeep_b, tlast_b};
        end else begin
            hold_b <= 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic b, input logic [31:0] d, input logic [3:0] k,
                             input logic l, input logic e);
        sel_b   = b;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_err   = e;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic push_exp(input logic b, input logic [31:0] d, input logic [3:0] k, input logic l);
        rx_fifo_entry_t ent;
        ent.data = d;
        ent.keep = k;
        ent.last = l;
        if (b) exp_b.push_back(ent);
        else   exp_a.push_back(ent);
    endtask

    task automatic send_frame(input logic b, input int fid, input int len,
                              input logic [3:0] last_keep, input logic err, input logic push);
        for (int i = 0; i < len; i++) begin
            logic [31:0] d;
            logic [3:0]  k;
            logic        l;
            d = {fid[15:0], i[15:0]};
            l = (i == len - 1);
            k = l ? last_keep : 4'hF;
            if (push) push_exp(b, d, k, l);
            send_beat(b, d, k, l, err && l);
        end
    endtask

    task automatic drain(input logic b);
        int t = 0;
        while (((b ? exp_b.size() : exp_a.size()) != 0 || (b ? tvalid_b : tvalid_a)) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(b ? "b_drain_left" : "a_drain_left", 64'(b ? exp_b.size() : exp_a.size()), 64'(0));
    endtask

    task automatic check_counters();
        check("a_frames_ok", 64'(ok_a), 64'(m_ok_a));
        check("a_frames_bad", 64'(bad_a), 64'(m_bad_a));
        check("a_frames_overflow", 64'(ovf_a), 64'(m_ovf_a));
        check("b_frames_ok", 64'(ok_b), 64'(m_ok_b));
        check("b_frames_overflow", 64'(ovf_b), 64'(m_ovf_b));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        s_data     = '0;
        s_keep     = '0;
        s_last     = 1'b0;
        s_err      = 1'b0;
        s_valid    = 1'b0;
        sel_b      = 1'b0;
        trdy_a_set = 1'b1;
        trdy_b     = 1'b0;
        rand_a     = 1'b0;
        rnd_a      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(tvalid_a), 64'(0));
        check("rst_tdata", 64'(tdata_a), 64'(0));
        check("rst_tkeep", 64'(tkeep_a), 64'(0));
        check("rst_tlast", 64'(tlast_a), 64'(0));
        check("rst_tvalid_b", 64'(tvalid_b), 64'(0));
        check_counters();
        rst_n = 1'b1;

        // 16-beat good frame, last keep 3; output may start only 2 cycles
        // after the edge that took the last beat.
        send_frame(1'b0, 1, 16, 4'h3, 1'b0, 1'b1);
        m_ok_a++;
        check("a_sf_no_early", 64'(tvalid_a), 64'(0));
        idle(1);
        check("a_lat_cycle1", 64'(tvalid_a), 64'(0));
        idle(1);
        check("a_lat_cycle2", 64'(tvalid_a), 64'(1));
        drain(1'b0);
        check_counters();

        // Errored 10-beat frame is rolled back; the following 4-beat one is kept.
        send_frame(1'b0, 2, 10, 4'hF, 1'b1, 1'b0);
        m_bad_a++;
        send_frame(1'b0, 3, 4, 4'h1, 1'b0, 1'b1);
        m_ok_a++;
        drain(1'b0);
        check_counters();

        // keep=0 beats (one flagged last+err) inside a frame are ignored.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] d;
            d = {16'd4, i[15:0]};
            push_exp(1'b0, d, (i == 5) ? 4'h7 : 4'hF, i == 5);
            send_beat(1'b0, d, (i == 5) ? 4'h7 : 4'hF, i == 5, 1'b0);
            if (i == 1) send_beat(1'b0, 32'hDEAD_BEEF, 4'h0, 1'b0, 1'b0);
            if (i == 3) send_beat(1'b0, 32'hBAD0_BAD0, 4'h0, 1'b1, 1'b1);
        end
        m_ok_a++;
        drain(1'b0);
        check_counters();

        // Depth-16 instance, output stalled: second frame overflows.
        send_frame(1'b1, 5, 12, 4'hF, 1'b0, 1'b1);
        m_ok_b++;
        send_frame(1'b1, 6, 8, 4'hF, 1'b0, 1'b0);
        m_ovf_b++;
        idle(2);
        check_counters();
        trdy_b = 1'b1;
        drain(1'b1);

        // Longer than the FIFO: always dropped; exactly FIFO-sized: kept.
        send_frame(1'b1, 7, 17, 4'hF, 1'b0, 1'b0);
        m_ovf_b++;
        send_frame(1'b1, 8, 16, 4'h3, 1'b0, 1'b1);
        m_ok_b++;
        drain(1'b1);
        check_counters();

        // 100 good frames of 1..64 beats under random output stalls.
        rand_a = 1'b1;
        for (int f = 0; f < 100; f++) begin
            int          len;
            logic [3:0]  lk;
            len = ((f * 37) % 64) + 1;
            case (len % 4)
                0:       lk = 4'hF;
                1:       lk = 4'h1;
                2:       lk = 4'h3;
                default: lk = 4'h7;
            endcase
            send_frame(1'b0, 100 + f, len, lk, 1'b0, 1'b1);
            m_ok_a++;
            idle(2 * len);
        end
        drain(1'b0);
        rand_a = 1'b0;
        check_counters();

        // Reset while a frame is partway out of the FIFO.
        trdy_a_set = 1'b0;
        send_frame(1'b0, 9, 8, 4'hF, 1'b0, 1'b1);
        idle(3);
        check("a_pre_reset_valid", 64'(tvalid_a), 64'(1));
        trdy_a_set = 1'b1;
        idle(3);
        rst_n      = 1'b0;
        trdy_a_set = 1'b0;
        exp_a.delete();
        exp_b.delete();
        m_ok_a = 0; m_bad_a = 0; m_ovf_a = 0;
        m_ok_b = 0; m_ovf_b = 0;
        idle(1);
        check("a_reset_tvalid", 64'(tvalid_a), 64'(0));
        check_counters();
        idle(1);
        rst_n      = 1'b1;
        trdy_a_set = 1'b1;
        send_frame(1'b0, 10, 8, 4'h3, 1'b0, 1'b1);
        m_ok_a++;
        drain(1'b0);
        check_counters();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
